// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared command/state encodings and default widths for the PC sequencer
package pc_seq_pkg;
   localparam int DEF_ADDR_W = 8;
   typedef enum logic [2:0] {
      CMD_SEQ  = 3'd0,
      CMD_JMP  = 3'd1,
      CMD_BR   = 3'd2,
      CMD_CALL = 3'd3,
      CMD_RET  = 3'd4,
      CMD_HALT = 3'd5
   } cmd_t;
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2,
      ST_HALT  = 2'd3
   } state_t;
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: fetch, command and status signals between control/decode and the PC sequencer
interface pc_sequencer_if #(parameter int ADDR_W = 8) ();
   logic              start, halt_req;
   logic              fetch_req, fetch_ack;
   logic [ADDR_W-1:0] addr_out;
   logic              cmd_valid, cmd_ready;
   logic [2:0]        cmd;
   logic [ADDR_W-1:0] target, offset;
   logic              stack_empty, stack_full, err, halted;
   modport master (
      output start, halt_req, fetch_ack, cmd_valid, cmd, target, offset,
      input  fetch_req, addr_out, cmd_ready, stack_empty, stack_full, err, halted
   );
   modport slave (
      input  start, halt_req, fetch_ack, cmd_valid, cmd, target, offset,
      output fetch_req, addr_out, cmd_ready, stack_empty, stack_full, err, halted
   );
endinterface

// File: rtl/pc_sequencer_ret_stack.sv
// ret_stack: return-address LIFO; pushes when full and pops when empty are ignored
module ret_stack #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      sp, sp_dec;
   assign sp_dec = sp - (AW+1)'(1);
   assign empty  = sp == '0;
   assign full   = sp == (AW+1)'(DEPTH);
   assign dout   = mem[sp_dec[AW-1:0]];
   always_ff @(posedge clk)
      if (rst) sp <= '0;
      else if (push && !full) sp <= sp + (AW+1)'(1);
      else if (pop && !empty) sp <= sp_dec;
   // contents survive reset; only the pointer is cleared
   always_ff @(posedge clk)
      if (push && !full) mem[sp[AW-1:0]] <= din;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the program counter, issues fetches and applies decode commands
module pc_sequencer import pc_seq_pkg::*; #(
   parameter int                ADDR_W      = DEF_ADDR_W,
   parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
   parameter int                STACK_DEPTH = 4
) (
   input logic          clk,
   input logic          rst,
   pc_sequencer_if.slave bus
);
   state_t            state;
   logic [ADDR_W-1:0] pc, pc_inc, ret_addr;
   logic              err, accept, push, pop, stack_empty, stack_full;
   assign pc_inc          = pc + ADDR_W'(1);
   assign bus.cmd_ready   = state == ST_EXEC && !bus.halt_req;
   assign accept          = bus.cmd_ready && bus.cmd_valid;
   assign push            = accept && bus.cmd == CMD_CALL && !stack_full;
   assign pop             = accept && bus.cmd == CMD_RET && !stack_empty;
   assign bus.fetch_req   = state == ST_FETCH;
   assign bus.halted      = state == ST_HALT;
   assign bus.addr_out    = pc;
   assign bus.err         = err;
   assign bus.stack_empty = stack_empty;
   assign bus.stack_full  = stack_full;
   ret_stack #(.WIDTH(ADDR_W), .DEPTH(STACK_DEPTH)) u_stack (
      .clk(clk), .rst(rst), .push(push), .pop(pop), .din(pc_inc),
      .dout(ret_addr), .empty(stack_empty), .full(stack_full)
   );
   always_ff @(posedge clk)
      if (rst) begin
         state <= ST_IDLE;
         pc    <= RESET_VEC;
         err   <= 1'b0;
      end else case (state)
         ST_IDLE: if (bus.start) state <= ST_FETCH;
         // an ack wins over a coincident halt; the halt is then taken in EXEC
         ST_FETCH: state <= bus.fetch_ack ? ST_EXEC : bus.halt_req ? ST_HALT : ST_FETCH;
         ST_EXEC:
            if (bus.halt_req) state <= ST_HALT;
            else if (bus.cmd_valid) begin
               state <= ST_FETCH;
               case (bus.cmd)
                  CMD_SEQ: pc <= pc_inc;
                  CMD_JMP: pc <= bus.target;
                  CMD_BR:  pc <= pc + bus.offset;
                  CMD_CALL:
                     if (stack_full) begin
                        err   <= 1'b1;
                        state <= ST_HALT;
                     end else pc <= bus.target;
                  CMD_RET:
                     if (stack_empty) begin
                        err   <= 1'b1;
                        state <= ST_HALT;
                     end else pc <= ret_addr;
                  CMD_HALT: begin
                     pc    <= pc_inc;
                     state <= ST_HALT;
                  end
                  default: begin
                     pc  <= pc_inc;
                     err <= 1'b1;
                  end
               endcase
            end
         ST_HALT:
            if (bus.start) begin
               state <= ST_FETCH;
               err   <= 1'b0;
            end
         default: state <= ST_IDLE;
      endcase
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard of expected fetch addresses plus per-scenario flag checks
module tb_pc_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;
   logic [7:0] exp_q[$];
   logic [7:0] m_stk[$];
   logic [7:0] m_pc = 8'h00;
   logic       prev_fr = 1'b0;

   pc_sequencer_if #(.ADDR_W(8)) bus ();
   pc_sequencer #(.ADDR_W(8), .RESET_VEC(8'h00), .STACK_DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   // every new FETCH must present the next address the model predicted
   always @(negedge clk) begin
      if (bus.fetch_req && !prev_fr) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_fetch got=%h want=none", bus.addr_out);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (bus.addr_out !== e) begin
               bad++;
               $display("FAIL fetch_addr got=%h want=%h", bus.addr_out, e);
            end
         end
      end
      prev_fr <= bus.fetch_req;
   end

   task automatic model(input logic [2:0] c, input logic [7:0] t, input logic [7:0] o);
      logic halt;
      halt = 1'b0;
      case (c)
         3'd0: m_pc = m_pc + 8'd1;
         3'd1: m_pc = t;
         3'd2: m_pc = m_pc + o;
         3'd3: if (m_stk.size() == 4) halt = 1'b1;
               else begin m_stk.push_back(m_pc + 8'd1); m_pc = t; end
         3'd4: if (m_stk.size() == 0) halt = 1'b1;
               else m_pc = m_stk.pop_back();
         3'd5: begin m_pc = m_pc + 8'd1; halt = 1'b1; end
         default: m_pc = m_pc + 8'd1;
      endcase
      if (!halt) exp_q.push_back(m_pc);
   endtask

   task automatic begin_fetch();
      exp_q.push_back(m_pc);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic do_fetch();
      int n = 0;
      while (!bus.fetch_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bus.fetch_req) begin
         total++;
         bad++;
         $display("FAIL fetch_timeout got=0 want=1");
      end
      bus.fetch_ack = 1'b1;
      @(negedge clk);
      bus.fetch_ack = 1'b0;
   endtask

   task automatic send(input logic [2:0] c, input logic [7:0] t, input logic [7:0] o);
      model(c, t, o);
      bus.cmd = c; bus.target = t; bus.offset = o; bus.cmd_valid = 1'b1;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      total++;
      if (bus.addr_out !== 8'h00) begin bad++; $display("FAIL reset_addr got=%h want=00", bus.addr_out); end
      total++;
      if ({bus.fetch_req, bus.cmd_ready, bus.stack_empty, bus.stack_full, bus.err, bus.halted} !== 6'b001000) begin
         bad++;
         $display("FAIL reset_flags got=%b want=001000", {bus.fetch_req, bus.cmd_ready, bus.stack_empty, bus.stack_full, bus.err, bus.halted});
      end
      bus.fetch_ack = 1'b1;
      @(negedge clk);
      bus.fetch_ack = 1'b0;
      total++;
      if (bus.fetch_req !== 1'b0 || bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL idle_ack_ignored got=%b%b want=00", bus.fetch_req, bus.cmd_ready); end
   endtask

   task automatic test_seq();
      begin_fetch();
      repeat (3) begin
         do_fetch();
         send(3'd0, 8'h00, 8'h00);
      end
      total++;
      if (bus.fetch_req !== 1'b1 || bus.addr_out !== 8'h03) begin bad++; $display("FAIL seq_addr got=%b/%h want=1/03", bus.fetch_req, bus.addr_out); end
   endtask

   task automatic test_wrap_branch();
      do_fetch(); send(3'd1, 8'hFE, 8'h00);
      do_fetch(); send(3'd0, 8'h00, 8'h00);
      total++;
      if (bus.addr_out !== 8'hFF) begin bad++; $display("FAIL seq_ff got=%h want=ff", bus.addr_out); end
      do_fetch(); send(3'd0, 8'h00, 8'h00);
      total++;
      if (bus.addr_out !== 8'h00) begin bad++; $display("FAIL seq_wrap got=%h want=00", bus.addr_out); end
      do_fetch(); send(3'd1, 8'h02, 8'h00);
      do_fetch(); send(3'd2, 8'h00, 8'hFC);
      total++;
      if (bus.addr_out !== 8'hFE) begin bad++; $display("FAIL br_back got=%h want=fe", bus.addr_out); end
   endtask

   task automatic test_call_ret();
      do_fetch(); send(3'd1, 8'h10, 8'h00);
      do_fetch(); send(3'd3, 8'h40, 8'h00);
      total++;
      if (bus.addr_out !== 8'h40 || bus.stack_empty !== 1'b0) begin bad++; $display("FAIL call got=%h/%b want=40/0", bus.addr_out, bus.stack_empty); end
      do_fetch(); send(3'd4, 8'h00, 8'h00);
      total++;
      if (bus.addr_out !== 8'h11 || bus.stack_empty !== 1'b1) begin bad++; $display("FAIL ret got=%h/%b want=11/1", bus.addr_out, bus.stack_empty); end
   endtask

   task automatic test_overflow();
      logic [7:0] tgt[4] = '{8'h40, 8'h50, 8'h60, 8'h70};
      for (int i = 0; i < 4; i++) begin
         do_fetch(); send(3'd3, tgt[i], 8'h00);
      end
      total++;
      if (bus.stack_full !== 1'b1) begin bad++; $display("FAIL stack_full got=%b want=1", bus.stack_full); end
      do_fetch(); send(3'd3, 8'h80, 8'h00);
      total++;
      if ({bus.err, bus.halted, bus.fetch_req} !== 3'b110 || bus.addr_out !== 8'h70) begin
         bad++;
         $display("FAIL overflow got=%b/%h want=110/70", {bus.err, bus.halted, bus.fetch_req}, bus.addr_out);
      end
      begin_fetch();
      total++;
      if (bus.err !== 1'b0 || bus.fetch_req !== 1'b1) begin bad++; $display("FAIL resume got=%b%b want=01", bus.err, bus.fetch_req); end
      repeat (4) begin
         do_fetch(); send(3'd4, 8'h00, 8'h00);
      end
      total++;
      if (bus.addr_out !== 8'h12 || bus.stack_empty !== 1'b1) begin bad++; $display("FAIL unwind got=%h/%b want=12/1", bus.addr_out, bus.stack_empty); end
   endtask

   task automatic test_underflow_illegal();
      do_fetch(); send(3'd4, 8'h00, 8'h00);
      total++;
      if ({bus.err, bus.halted} !== 2'b11 || bus.addr_out !== 8'h12) begin bad++; $display("FAIL underflow got=%b/%h want=11/12", {bus.err, bus.halted}, bus.addr_out); end
      begin_fetch();
      do_fetch(); send(3'd1, 8'h20, 8'h00);
      do_fetch(); send(3'd7, 8'h00, 8'h00);
      total++;
      if ({bus.err, bus.halted, bus.fetch_req} !== 3'b101 || bus.addr_out !== 8'h21) begin
         bad++;
         $display("FAIL illegal got=%b/%h want=101/21", {bus.err, bus.halted, bus.fetch_req}, bus.addr_out);
      end
   endtask

   task automatic test_halt_req();
      do_fetch();
      bus.halt_req = 1'b1; bus.cmd = 3'd1; bus.target = 8'h99; bus.cmd_valid = 1'b1;
      #1;
      total++;
      if (bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL halt_ready got=%b want=0", bus.cmd_ready); end
      @(negedge clk);
      bus.halt_req = 1'b0; bus.cmd_valid = 1'b0;
      total++;
      if (bus.halted !== 1'b1 || bus.addr_out !== 8'h21) begin bad++; $display("FAIL halt_exec got=%b/%h want=1/21", bus.halted, bus.addr_out); end
      begin_fetch();
      total++;
      if (bus.err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b want=0", bus.err); end
   endtask

   task automatic test_fetch_halt();
      bus.halt_req = 1'b1; bus.fetch_ack = 1'b1;
      @(negedge clk);
      bus.fetch_ack = 1'b0;
      total++;
      if (bus.halted !== 1'b0 || bus.cmd_ready !== 1'b0 || bus.fetch_req !== 1'b0) begin
         bad++;
         $display("FAIL ack_halt_exec got=%b%b%b want=000", bus.halted, bus.cmd_ready, bus.fetch_req);
      end
      @(negedge clk);
      bus.halt_req = 1'b0;
      total++;
      if (bus.halted !== 1'b1 || bus.addr_out !== 8'h21) begin bad++; $display("FAIL ack_halt got=%b/%h want=1/21", bus.halted, bus.addr_out); end
      begin_fetch();
      bus.halt_req = 1'b1;
      @(negedge clk);
      bus.halt_req = 1'b0;
      total++;
      if (bus.halted !== 1'b1 || bus.fetch_req !== 1'b0) begin bad++; $display("FAIL fetch_halt got=%b%b want=10", bus.halted, bus.fetch_req); end
      begin_fetch();
      do_fetch(); send(3'd5, 8'h00, 8'h00);
      total++;
      if (bus.halted !== 1'b1 || bus.addr_out !== 8'h22 || bus.err !== 1'b0) begin
         bad++;
         $display("FAIL cmd_halt got=%b/%h/%b want=1/22/0", bus.halted, bus.addr_out, bus.err);
      end
      begin_fetch();
   endtask

   task automatic test_rst_mid_fetch();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_pc = 8'h00;
      m_stk.delete();
      total++;
      if ({bus.fetch_req, bus.cmd_ready, bus.halted} !== 3'b000 || bus.addr_out !== 8'h00) begin
         bad++;
         $display("FAIL rst_fetch got=%b/%h want=000/00", {bus.fetch_req, bus.cmd_ready, bus.halted}, bus.addr_out);
      end
      bus.fetch_ack = 1'b1;
      @(negedge clk);
      bus.fetch_ack = 1'b0;
      total++;
      if (bus.fetch_req !== 1'b0 || bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL late_ack got=%b%b want=00", bus.fetch_req, bus.cmd_ready); end
   endtask

   initial begin
      bus.start = 1'b0; bus.halt_req = 1'b0; bus.fetch_ack = 1'b0;
      bus.cmd_valid = 1'b0; bus.cmd = 3'd0; bus.target = 8'h00; bus.offset = 8'h00;
      test_reset();
      test_seq();
      test_wrap_branch();
      test_call_ret();
      test_overflow();
      test_underflow_illegal();
      test_halt_req();
      test_fetch_halt();
      test_rst_mid_fetch();
      @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin bad++; $display("FAIL missing_fetches got=%0d want=0", exp_q.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Controller that owns the 8-bit program counter and sequences instruction fetch.
- Issues fetch requests at the current PC and waits for the memory handshake.
- Accepts one control command per instruction and computes the next PC: sequential, jump, relative branch, call or return.
- Sits between the instruction memory interface and the decode stage, and holds a small return-address stack.

Parameters:
- ADDR_W, 8, PC and address width.
- RESET_VEC, 8'h00, PC value loaded on reset.
- STACK_DEPTH, 4, return-address stack entries (power of two, at least 2).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  leave IDLE/HALT and begin fetching at current PC.
- halt_req  in  1  request stop at the next decision point.
- fetch_req  out  1  fetch request; addr_out is valid while high.
- fetch_ack  in  1  memory accepted fetch (single-cycle pulse).
- addr_out  out  ADDR_W  current PC.
- cmd_valid  in  1  decode presents a command.
- cmd_ready  out  1  sequencer accepts a command this cycle.
- cmd  in  3  0 SEQ, 1 JMP, 2 BR, 3 CALL, 4 RET, 5 HALT, 6-7 illegal.
- target  in  ADDR_W  absolute address for JMP/CALL.
- offset  in  ADDR_W  signed two's-complement displacement for BR.
- stack_empty  out  1  return stack holds 0 entries.
- stack_full  out  1  return stack holds STACK_DEPTH entries.
- err  out  1  sticky error flag.
- halted  out  1  high in HALT state.

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous and active-high.
- Reset values:
  - State IDLE, addr_out=RESET_VEC.
  - Stack pointer 0, stack_empty=1, stack_full=0.
  - fetch_req=0, cmd_ready=0, err=0, halted=0.
- States: IDLE, FETCH, EXEC, HALT.
- IDLE: outputs inactive. start moves to FETCH next cycle.
- FETCH:
  - fetch_req=1, addr_out stable.
  - fetch_ack moves to EXEC next cycle.
  - halt_req without fetch_ack moves to HALT.
  - If fetch_ack and halt_req coincide, go to EXEC; the halt is taken in EXEC.
- EXEC:
  - cmd_ready = 1 when state==EXEC and halt_req==0 (combinational).
  - A command is accepted when cmd_valid and cmd_ready are both high; the PC updates on that same edge.
  - Next state is FETCH except where stated below.
- EXEC with halt_req=1: go to HALT, no command accepted, PC unchanged.
- Command actions:
  - SEQ: PC = PC+1, mod 2^ADDR_W; 8'hFF wraps to 8'h00.
  - JMP: PC = target.
  - BR: PC = PC + offset, mod 2^ADDR_W (e.g. 8'h02 + 8'hFC = 8'hFE).
  - CALL: push PC+1 (wrapped), then PC = target.
    - If the stack is full: no push, PC unchanged, err=1, go to HALT.
  - RET: pop into PC.
    - If the stack is empty: PC unchanged, err=1, go to HALT.
  - HALT: PC = PC+1, go to HALT.
  - Illegal (6-7): err=1, PC = PC+1, continue to FETCH.
- HALT:
  - halted=1, fetch_req=0, cmd_ready=0.
  - start moves to FETCH at the current PC and clears err on the same edge.
- start is ignored in FETCH and EXEC.
- err is sticky: set by overflow, underflow or illegal command; cleared only by rst or start in HALT.
- Stack:
  - LIFO; push writes mem[sp] and increments sp; pop decrements sp and reads mem[sp-1].
  - Pop data is available combinationally in the same cycle.
  - Contents are not cleared by reset; only sp resets.
- rst in any state, including mid-fetch with fetch_req high, forces the reset values on the next edge. An outstanding fetch is abandoned and a later fetch_ack in IDLE is ignored.
- fetch_ack outside FETCH is ignored. cmd_valid outside EXEC is ignored.

Decomposition:
- Shared package pc_seq_pkg:
  - Command encodings CMD_SEQ..CMD_HALT.
  - State encodings.
  - ADDR_W default.
- Sub-module ret_stack:
  - Parameterised LIFO (width ADDR_W, depth STACK_DEPTH).
  - Ports: clk, rst, push, pop, din, dout, empty, full.
  - Overflow and underflow guarding is done in pc_sequencer; ret_stack treats an illegal push or pop as a no-op.

Test Plan:
- Reset then start; ack each fetch; send SEQ 3 times -> addr_out 00,01,02,03; fetch_req high in each FETCH.
- PC=8'hFE, SEQ twice -> 8'hFF then 8'h00 (wrap). PC=8'h02, BR offset 8'hFC -> 8'hFE.
- CALL target 8'h40 from PC 8'h10 -> PC 8'h40, stack_empty=0. RET -> PC 8'h11, stack_empty=1.
- 4 nested CALLs -> stack_full=1. A 5th CALL -> err=1, halted=1, PC unchanged. start -> err=0, fetch resumes at the same PC.
- RET with empty stack -> err=1, HALT. Illegal cmd 7 at PC 8'h20 -> err=1, PC 8'h21, no halt.
- halt_req asserted in EXEC together with cmd_valid JMP -> cmd_ready=0, PC unchanged, HALT. rst during FETCH -> next cycle IDLE, addr_out=8'h00, fetch_req=0.
